// File: rtl/uart_cmd_pkg.sv
// Shared opcode, status and FSM state encodings for the UART command controller.
// No logic; constants and types only.
// Imported by uart_cmd_ctrl and by anything that decodes its responses.
package uart_cmd_pkg;

    // Command opcodes received over the UART
    localparam logic [7:0] OP_WR   = 8'h57;  // 'W'
    localparam logic [7:0] OP_RD   = 8'h52;  // 'R'

    // Status bytes returned as the first response byte
    localparam logic [7:0] ST_OK   = 8'h4B;  // 'K' write acknowledged
    localparam logic [7:0] ST_DATA = 8'h44;  // 'D' read data follows
    localparam logic [7:0] ST_ERR  = 8'h45;  // 'E' bad opcode or checksum
    localparam logic [7:0] ST_TMO  = 8'h54;  // 'T' bus access timed out

    // FSM state encoding
    typedef logic [3:0] state_t;

    localparam state_t IDLE        = 4'd0;
    localparam state_t GET_ADDR    = 4'd1;
    localparam state_t GET_DATA    = 4'd2;
    localparam state_t GET_CSUM    = 4'd3;
    localparam state_t BUS_WR      = 4'd4;
    localparam state_t BUS_RD      = 4'd5;
    localparam state_t SEND_STATUS = 4'd6;
    localparam state_t SEND_DATA   = 4'd7;
    localparam state_t SEND_CSUM   = 4'd8;

endpackage

// File: rtl/uart_cmd_ctrl.sv
// UART command decoder: parses 'W' addr data / 'R' addr, drives a register bus, replies status (+data); optional XOR checksum under UART_CMD_CHECKSUM_EN.
// Latency: one byte per cycle when FIFOs allow; bus access takes ack delay (max TIMEOUT cycles) before the response.
// Backpressure: stalls in GET_* while rx_empty, in SEND_* while tx_full; bus strobe held until reg_ack or timeout.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int DBITS   = 8,
    parameter int TIMEOUT = 255,
    parameter int TO_BITS = 8
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    // RX FIFO
    input  logic             rx_empty,
    input  logic [DBITS-1:0] read_data,
    output logic             read_uart,
    // TX FIFO
    input  logic             tx_full,
    output logic             write_uart,
    output logic [DBITS-1:0] write_data,
    // register bus
    output logic [DBITS-1:0] reg_addr,
    output logic [DBITS-1:0] reg_wdata,
    input  logic [DBITS-1:0] reg_rdata,
    output logic             reg_we,
    output logic             reg_re,
    input  logic             reg_ack,
    output logic             busy
);

`ifdef UART_CMD_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    state_t             state_q, state_d;
    logic               is_wr_q;
    logic [DBITS-1:0]   addr_q, wdata_q, rdata_q, status_q;
    logic [TO_BITS-1:0] to_cnt_q;

    logic               pop, push, in_bus, bus_tmo, op_valid;
    logic [DBITS-1:0]   tx_byte;

`ifdef UART_CMD_CHECKSUM_EN
    logic [DBITS-1:0]   rx_csum_q, tx_csum_q;
    logic               csum_bad;
    assign csum_bad = (read_data != rx_csum_q);
`endif

    // Pops and pushes are suppressed while reset is held so the FIFOs see no side effects
    assign pop = !reset && !rx_empty &&
                 (state_q == IDLE || state_q == GET_ADDR ||
                  state_q == GET_DATA || state_q == GET_CSUM);
    assign push = !reset && !tx_full &&
                  (state_q == SEND_STATUS || state_q == SEND_DATA || state_q == SEND_CSUM);

    assign in_bus   = (state_q == BUS_WR) || (state_q == BUS_RD);
    // Ack on the final allowed cycle still wins over the timeout
    assign bus_tmo  = in_bus && !reg_ack && (to_cnt_q == TO_BITS'(TIMEOUT - 1));
    assign op_valid = (read_data == DBITS'(OP_WR)) || (read_data == DBITS'(OP_RD));

    // Select the byte presented to the TX FIFO in each send state
    always_comb begin
        tx_byte = '0;
        case (state_q)
            SEND_STATUS: tx_byte = status_q;
            SEND_DATA:   tx_byte = rdata_q;
`ifdef UART_CMD_CHECKSUM_EN
            SEND_CSUM:   tx_byte = tx_csum_q;
`endif
            default:     tx_byte = '0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:
                if (pop) state_d = op_valid ? GET_ADDR : SEND_STATUS;
            GET_ADDR:
                if (pop) state_d = is_wr_q ? GET_DATA : (CSUM_EN ? GET_CSUM : BUS_RD);
            GET_DATA:
                if (pop) state_d = CSUM_EN ? GET_CSUM : BUS_WR;
`ifdef UART_CMD_CHECKSUM_EN
            GET_CSUM:
                if (pop) state_d = csum_bad ? SEND_STATUS : (is_wr_q ? BUS_WR : BUS_RD);
`endif
            BUS_WR, BUS_RD:
                if (reg_ack || bus_tmo) state_d = SEND_STATUS;
            SEND_STATUS:
                if (push) state_d = (status_q == DBITS'(ST_DATA)) ? SEND_DATA :
                                    (CSUM_EN ? SEND_CSUM : IDLE);
            SEND_DATA:
                if (push) state_d = CSUM_EN ? SEND_CSUM : IDLE;
`ifdef UART_CMD_CHECKSUM_EN
            SEND_CSUM:
                if (push) state_d = IDLE;
`endif
            default:
                state_d = IDLE;
        endcase
    end

    // State, command fields, bus timeout counter and response status
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q  <= IDLE;
            is_wr_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            status_q <= '0;
            to_cnt_q <= '0;
        end else begin
            state_q <= state_d;

            if (in_bus && !reg_ack) to_cnt_q <= to_cnt_q + 1'b1;
            else                    to_cnt_q <= '0;

            case (state_q)
                IDLE: if (pop) begin
                    is_wr_q <= (read_data == DBITS'(OP_WR));
                    if (!op_valid) status_q <= DBITS'(ST_ERR);
                end
                GET_ADDR: if (pop) addr_q  <= read_data;
                GET_DATA: if (pop) wdata_q <= read_data;
`ifdef UART_CMD_CHECKSUM_EN
                GET_CSUM: if (pop && csum_bad) status_q <= DBITS'(ST_ERR);
`endif
                BUS_WR: begin
                    if (reg_ack)      status_q <= DBITS'(ST_OK);
                    else if (bus_tmo) status_q <= DBITS'(ST_TMO);
                end
                BUS_RD: begin
                    if (reg_ack) begin
                        status_q <= DBITS'(ST_DATA);
                        rdata_q  <= reg_rdata;
                    end else if (bus_tmo) begin
                        status_q <= DBITS'(ST_TMO);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef UART_CMD_CHECKSUM_EN
    // Running XOR of command bytes (restarted by the opcode) and of response bytes (restarted by the status)
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            rx_csum_q <= '0;
            tx_csum_q <= '0;
        end else begin
            if (pop)  rx_csum_q <= (state_q == IDLE) ? read_data : (rx_csum_q ^ read_data);
            if (push) tx_csum_q <= (state_q == SEND_STATUS) ? status_q : (tx_csum_q ^ tx_byte);
        end
    end
`endif

    assign read_uart  = pop;
    assign write_uart = push;
    assign write_data = push ? tx_byte : '0;
    assign reg_we     = !reset && (state_q == BUS_WR);
    assign reg_re     = !reset && (state_q == BUS_RD);
    assign reg_addr   = (reg_we || reg_re) ? addr_q : '0;
    assign reg_wdata  = reg_we ? wdata_q : '0;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: table of commands with hand-computed responses plus corner sequences.
// RX FIFO and register slave are modelled in the bench; ack arrives a fixed number of cycles after strobe entry.
// Inputs change 1-2 ns after the rising edge; outputs are sampled on the falling edge.
module tb_uart_cmd_ctrl;

`ifdef UART_CMD_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic       clk_100MHz = 1'b0;
    logic       reset      = 1'b1;
    logic       rx_empty   = 1'b1;
    logic [7:0] read_data  = 8'h00;
    logic       tx_full    = 1'b0;
    logic [7:0] reg_rdata  = 8'h00;
    logic       reg_ack    = 1'b0;
    logic       read_uart, write_uart, reg_we, reg_re, busy;
    logic [7:0] write_data, reg_addr, reg_wdata;

    always #5 clk_100MHz = ~clk_100MHz;

    uart_cmd_ctrl #(.DBITS(8), .TIMEOUT(255), .TO_BITS(8)) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .rx_empty   (rx_empty),
        .read_data  (read_data),
        .read_uart  (read_uart),
        .tx_full    (tx_full),
        .write_uart (write_uart),
        .write_data (write_data),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .reg_we     (reg_we),
        .reg_re     (reg_re),
        .reg_ack    (reg_ack),
        .busy       (busy)
    );

    typedef struct {
        logic [23:0] cmd;       // command bytes, first in [23:16]
        int          n_cmd;
        int          gap;       // idle cycles between command bytes
        int          ack_dly;   // cycles after strobe entry before ack, -1 = never
        logic [7:0]  rdata;
        logic [15:0] rsp;       // expected response bytes, first in [15:8]
        int          n_rsp;
        int          exp_we;
        int          exp_re;
        int          exp_strobe;
        logic [7:0]  exp_addr;
        logic [7:0]  exp_wdata;
    } vec_t;

    logic [7:0] rx_q[$];
    logic [7:0] tx_got[$];
    bit         do_pop;
    bit         force_ack;
    int         ack_dly = -1;
    int         st_cnt;
    int         we_cnt, re_cnt, strobe_cyc, proto_err;
    bit         we_prev, re_prev;
    logic [7:0] last_addr, last_wdata;
    int         n_cmp, n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100MHz);
        #2;
    endtask

    task automatic clear_mon();
        tx_got.delete();
        we_cnt = 0; re_cnt = 0; strobe_cyc = 0;
        last_addr = 8'h00; last_wdata = 8'h00;
    endtask

    // Falling-edge monitor: records pushes, strobes and protocol violations
    initial forever begin
        @(negedge clk_100MHz);
        do_pop = read_uart;
        if (read_uart && rx_empty)              proto_err++;
        if (write_uart && tx_full)              proto_err++;
        if (reg_we && reg_re)                   proto_err++;
        if (reg_re && reg_wdata != 8'h00)       proto_err++;
        if (!reg_we && !reg_re && reg_addr != 8'h00) proto_err++;
        if (!write_uart && write_data != 8'h00) proto_err++;
        if (write_uart) tx_got.push_back(write_data);
        if (reg_we || reg_re) begin
            strobe_cyc++;
            last_addr  = reg_addr;
            last_wdata = reg_wdata;
        end
        if (reg_we && !we_prev) we_cnt++;
        if (reg_re && !re_prev) re_cnt++;
        we_prev = reg_we;
        re_prev = reg_re;
    end

    // RX FIFO model and register slave, updated 1 ns after the rising edge
    initial forever begin
        logic ack_v;
        @(posedge clk_100MHz);
        #1;
        if (do_pop && rx_q.size() > 0) void'(rx_q.pop_front());
        do_pop    = 1'b0;
        rx_empty  = (rx_q.size() == 0);
        read_data = rx_empty ? 8'h00 : rx_q[0];
        ack_v     = 1'b0;
        if (reg_we || reg_re) begin
            ack_v = (ack_dly >= 0) && (st_cnt == ack_dly);
            st_cnt++;
        end else begin
            st_cnt = 0;
        end
        reg_ack = ack_v || force_ack;
    end

    task automatic wait_done(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            if (rx_q.size() == 0 && !busy) done = 1'b1;
        end
        chk({name, "_done"}, done, 1);
        repeat (4) tick();
    endtask

    task automatic check_tx(input string name, input logic [7:0] exp_q[$]);
        chk({name, "_tx_count"}, tx_got.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < tx_got.size()) chk($sformatf("%s_tx%0d", name, i), tx_got[i], exp_q[i]);
        end
    endtask

    task automatic run_vec(input string name, input vec_t v);
        logic [7:0] b, cs;
        logic [7:0] exp_q[$];
        clear_mon();
        reg_rdata = v.rdata;
        ack_dly   = v.ack_dly;
        cs = 8'h00;
        for (int i = 0; i < v.n_cmd; i++) begin
            b = v.cmd[23-8*i -: 8];
            rx_q.push_back(b);
            cs = cs ^ b;
            repeat (v.gap) tick();
        end
        if (CSUM_EN && v.n_cmd > 1) rx_q.push_back(cs);
        wait_done(name, 700);
        cs = 8'h00;
        for (int i = 0; i < v.n_rsp; i++) begin
            b = v.rsp[15-8*i -: 8];
            exp_q.push_back(b);
            cs = cs ^ b;
        end
        if (CSUM_EN) exp_q.push_back(cs);
        check_tx(name, exp_q);
        chk({name, "_we"}, we_cnt, v.exp_we);
        chk({name, "_re"}, re_cnt, v.exp_re);
        chk({name, "_strobe_cycles"}, strobe_cyc, v.exp_strobe);
        if (v.exp_we + v.exp_re > 0) chk({name, "_addr"}, last_addr, v.exp_addr);
        if (v.exp_we > 0)            chk({name, "_wdata"}, last_wdata, v.exp_wdata);
        chk({name, "_idle"}, busy, 0);
    endtask

    function automatic vec_t mk(input logic [23:0] cmd, input int n_cmd, input int gap,
                                input int dly, input logic [7:0] rd, input logic [15:0] rsp,
                                input int n_rsp, input int we, input int re, input int strobe,
                                input logic [7:0] addr, input logic [7:0] wdata);
        vec_t v;
        v.cmd = cmd; v.n_cmd = n_cmd; v.gap = gap; v.ack_dly = dly; v.rdata = rd;
        v.rsp = rsp; v.n_rsp = n_rsp; v.exp_we = we; v.exp_re = re;
        v.exp_strobe = strobe; v.exp_addr = addr; v.exp_wdata = wdata;
        return v;
    endfunction

    initial begin
        vec_t vecs[7];
        vec_t v;
        logic [7:0] exp_q[$];
        bit seen;

        //           cmd          n  gap dly  rdata  rsp      n  we re strobe addr  wdata
        vecs[0] = mk(24'h5710A5,  3, 0,  3,   8'h00, 16'h4B00, 1, 1, 0, 4,   8'h10, 8'hA5);
        vecs[1] = mk(24'h522200,  2, 0,  0,   8'h3C, 16'h443C, 2, 0, 1, 1,   8'h22, 8'h00);
        vecs[2] = mk(24'h990000,  1, 0,  0,   8'h00, 16'h4500, 1, 0, 0, 0,   8'h00, 8'h00);
        vecs[3] = mk(24'h520500,  2, 0,  -1,  8'h00, 16'h5400, 1, 0, 1, 255, 8'h05, 8'h00);
        vecs[4] = mk(24'h57FF00,  3, 7,  0,   8'h00, 16'h4B00, 1, 1, 0, 1,   8'hFF, 8'h00);
        vecs[5] = mk(24'h528000,  2, 3,  10,  8'hFF, 16'h44FF, 2, 0, 1, 11,  8'h80, 8'h00);
        vecs[6] = mk(24'h57005A,  3, 0,  254, 8'h00, 16'h4B00, 1, 1, 0, 255, 8'h00, 8'h5A);

        // Reset state
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_we", reg_we, 0);
        chk("rst_re", reg_re, 0);
        reset = 1'b0;
        tick();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_read_uart", read_uart, 0);
        chk("post_rst_write_uart", write_uart, 0);
        chk("post_rst_addr", reg_addr, 0);
        chk("post_rst_wdata", reg_wdata, 0);
        chk("post_rst_write_data", write_data, 0);

        // Table-driven commands
        foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Stray ack outside bus states has no effect
        force_ack = 1'b1;
        repeat (3) tick();
        run_vec("stray_ack", vecs[2]);
        force_ack = 1'b0;
        tick();

        // TX FIFO full for 20 cycles while a read response is pending
        tx_full = 1'b1;
        v = mk(24'h523300, 2, 0, 1, 8'h77, 16'h4477, 2, 0, 1, 2, 8'h33, 8'h00);
        clear_mon();
        reg_rdata = v.rdata;
        ack_dly   = v.ack_dly;
        rx_q.push_back(8'h52);
        rx_q.push_back(8'h33);
        if (CSUM_EN) rx_q.push_back(8'h52 ^ 8'h33);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (re_cnt == 1 && !reg_re) seen = 1'b1;
        end
        chk("full_bus_done", seen, 1);
        repeat (20) tick();
        chk("full_no_push", tx_got.size(), 0);
        chk("full_busy", busy, 1);
        tx_full = 1'b0;
        wait_done("full", 100);
        exp_q = '{8'h44, 8'h77};
        if (CSUM_EN) exp_q.push_back(8'h44 ^ 8'h77);
        check_tx("full", exp_q);
        chk("full_addr", last_addr, 8'h33);

        // Reset mid-command abandons it silently
        clear_mon();
        rx_q.push_back(8'h57);
        rx_q.push_back(8'h10);
        repeat (10) tick();
        chk("midrst_stalled_busy", busy, 1);
        reset = 1'b1;
        tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_we", reg_we, 0);
        reset = 1'b0;
        repeat (10) tick();
        chk("midrst_no_tx", tx_got.size(), 0);
        chk("midrst_no_we", we_cnt, 0);
        chk("midrst_no_re", re_cnt, 0);
        chk("midrst_idle", busy, 0);
        run_vec("after_rst", mk(24'h521000, 2, 0, 2, 8'h5C, 16'h445C, 2, 0, 1, 3, 8'h10, 8'h00));

`ifdef UART_CMD_CHECKSUM_EN
        // Bad checksum: no bus access, 'E' plus its checksum
        clear_mon();
        rx_q.push_back(8'h52);
        rx_q.push_back(8'h10);
        rx_q.push_back(8'h00);
        wait_done("bad_csum", 100);
        exp_q = '{8'h45, 8'h45};
        check_tx("bad_csum", exp_q);
        chk("bad_csum_re", re_cnt, 0);
        chk("bad_csum_we", we_cnt, 0);
`endif

        chk("protocol_violations", proto_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
